// File: rtl/sb_pkg.sv
// Shared constants for the issue scoreboard: stall-cause bit positions
// and the default configuration used by the controller and its interface.
package sb_pkg;

    localparam int SB_CAUSE_DATA   = 0;
    localparam int SB_CAUSE_STRUCT = 1;
    localparam int SB_CAUSE_SERIAL = 2;
    localparam int SB_CAUSE_W      = 3;

    localparam int SB_ISSUE_W = 2;
    localparam int SB_NUM_FU  = 3;
    localparam int SB_NREG    = 32;
    localparam int SB_RA_W    = $clog2(SB_NREG);

endpackage

// File: rtl/sb_issue_ctrl_if.sv
// Decode-to-scoreboard bundle: per-lane instruction descriptors, FU completion,
// and the issue decision returned to decode.
interface sb_issue_ctrl_if import sb_pkg::*; #(
    parameter int ISSUE_W = SB_ISSUE_W,
    parameter int NUM_FU  = SB_NUM_FU,
    parameter int RA_W    = SB_RA_W
);
    logic [ISSUE_W-1:0]          lane_vld;
    logic [ISSUE_W*RA_W-1:0]     lane_rs1;
    logic [ISSUE_W*RA_W-1:0]     lane_rs2;
    logic [ISSUE_W-1:0]          lane_rs1_en;
    logic [ISSUE_W-1:0]          lane_rs2_en;
    logic [ISSUE_W*RA_W-1:0]     lane_rd;
    logic [ISSUE_W-1:0]          lane_rd_en;
    logic [ISSUE_W*NUM_FU-1:0]   lane_fu_ok;
    logic [ISSUE_W-1:0]          lane_serial;
    logic                        flush;
    logic [NUM_FU-1:0]           fu_done;
    logic [ISSUE_W-1:0]          lane_issue;
    logic [ISSUE_W*NUM_FU-1:0]   lane_fu_sel;
    logic [ISSUE_W*SB_CAUSE_W-1:0] stall_cause;
    logic                        sb_idle;

    modport master (
        output lane_vld, lane_rs1, lane_rs2, lane_rs1_en, lane_rs2_en,
               lane_rd, lane_rd_en, lane_fu_ok, lane_serial, flush, fu_done,
        input  lane_issue, lane_fu_sel, stall_cause, sb_idle
    );

    modport slave (
        input  lane_vld, lane_rs1, lane_rs2, lane_rs1_en, lane_rs2_en,
               lane_rd, lane_rd_en, lane_fu_ok, lane_serial, flush, fu_done,
        output lane_issue, lane_fu_sel, stall_cause, sb_idle
    );
endinterface

// File: rtl/sb_fu_pick.sv
// Combinational picker: one-hot grant of the lowest-index FU that the lane
// can use and that nobody (busy table or older lane) has claimed.
module sb_fu_pick #(
    parameter int NUM_FU = 3
) (
    input  logic [NUM_FU-1:0] ok,
    input  logic [NUM_FU-1:0] claimed,
    output logic [NUM_FU-1:0] grant
);

    // Scan downward so the last hit, the lowest index, wins.
    always_comb begin
        grant = '0;
        for (int f = NUM_FU - 1; f >= 0; f--) begin
            if (ok[f] && !claimed[f]) begin
                grant    = '0;
                grant[f] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sb_issue_ctrl.sv
// In-order multi-issue scoreboard binding decode lanes to free FUs.
// Define SB_PERF_CNT_EN to add lane-0 stall-cause counters as output ports.
module sb_issue_ctrl import sb_pkg::*; #(
    parameter int ISSUE_W = SB_ISSUE_W,
    parameter int NUM_FU  = SB_NUM_FU,
    parameter int NREG    = SB_NREG,
    parameter int RA_W    = $clog2(NREG)
) (
    input  logic clk,
    input  logic rst,
    sb_issue_ctrl_if.slave sb
`ifdef SB_PERF_CNT_EN
    ,
    output logic [31:0] cnt_data,
    output logic [31:0] cnt_struct,
    output logic [31:0] cnt_serial
`endif
);

    logic [NREG-1:0]   pend;
    logic [NUM_FU-1:0] fu_busy;
    logic [RA_W-1:0]   fu_rd [NUM_FU];
    logic [NUM_FU-1:0] fu_rd_en;
    logic              machine_idle;

    logic [ISSUE_W-1:0]            issue_vec;
    logic [ISSUE_W*NUM_FU-1:0]     sel_vec;
    logic [ISSUE_W*SB_CAUSE_W-1:0] cause_vec;

    assign machine_idle = !(|fu_busy) && !(|pend);

    // Lanes are evaluated oldest first; each passes its claimed FUs, the
    // registers it will write and its go/no-go to the next younger lane.
    for (genvar i = 0; i < ISSUE_W; i++) begin : g_lane
        logic              vld, serial, rs1_en, rs2_en, rd_en;
        logic [RA_W-1:0]   rs1, rs2, rd;
        logic [NUM_FU-1:0] ok, grant, sel, claim_in, claim_out;
        logic [NREG-1:0]   wr_in, wr_out;
        logic              go_in, go_out;
        logic              haz, no_fu, ser_blk, issue;
        logic [SB_CAUSE_W-1:0] cause;

        assign vld    = sb.lane_vld[i];
        assign serial = sb.lane_serial[i];
        assign rs1_en = sb.lane_rs1_en[i];
        assign rs2_en = sb.lane_rs2_en[i];
        assign rd_en  = sb.lane_rd_en[i];
        assign rs1    = sb.lane_rs1[i*RA_W +: RA_W];
        assign rs2    = sb.lane_rs2[i*RA_W +: RA_W];
        assign rd     = sb.lane_rd[i*RA_W +: RA_W];
        assign ok     = sb.lane_fu_ok[i*NUM_FU +: NUM_FU];

        if (i == 0) begin : g_head
            assign claim_in = '0;
            assign wr_in    = '0;
            assign go_in    = 1'b1;
        end else begin : g_tail
            assign claim_in = g_lane[i-1].claim_out;
            assign wr_in    = g_lane[i-1].wr_out;
            assign go_in    = g_lane[i-1].go_out;
        end

        sb_fu_pick #(.NUM_FU(NUM_FU)) u_pick (
            .ok      (ok),
            .claimed (claim_in | fu_busy),
            .grant   (grant)
        );

        // WAR against an older lane is deliberately absent: older lanes read at issue.
        always_comb begin
            haz = 1'b0;
            if (rs1_en && (rs1 != '0) && (pend[rs1] || wr_in[rs1])) haz = 1'b1;
            if (rs2_en && (rs2 != '0) && (pend[rs2] || wr_in[rs2])) haz = 1'b1;
            if (rd_en  && (rd  != '0) && (pend[rd]  || wr_in[rd]))  haz = 1'b1;
            no_fu   = ~|grant;
            ser_blk = serial && !((i == 0) && machine_idle);
            issue   = !rst && !sb.flush && go_in && vld && !haz && !no_fu && !ser_blk;
            cause   = '0;
            if (!rst && !sb.flush && go_in && vld && !issue) begin
                cause[SB_CAUSE_DATA]   = haz;
                cause[SB_CAUSE_STRUCT] = no_fu;
                cause[SB_CAUSE_SERIAL] = ser_blk;
            end
            sel       = issue ? grant : '0;
            claim_out = claim_in | sel;
            wr_out    = wr_in;
            if (issue && rd_en && (rd != '0)) wr_out[rd] = 1'b1;
            go_out    = go_in && (!vld || issue) && !(issue && serial);
        end

        assign issue_vec[i]                             = issue;
        assign sel_vec[i*NUM_FU +: NUM_FU]              = sel;
        assign cause_vec[i*SB_CAUSE_W +: SB_CAUSE_W]    = cause;
    end

    assign sb.lane_issue  = issue_vec;
    assign sb.lane_fu_sel = sel_vec;
    assign sb.stall_cause = cause_vec;
    assign sb.sb_idle     = rst || machine_idle;

    // Completions are applied before new issues; they never touch the same FU or pend bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            fu_busy  <= '0;
            fu_rd_en <= '0;
            for (int f = 0; f < NUM_FU; f++) fu_rd[f] <= '0;
        end else begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (sb.fu_done[f] && fu_busy[f]) begin
                    fu_busy[f] <= 1'b0;
                    if (fu_rd_en[f]) pend[fu_rd[f]] <= 1'b0;
                end
            end
            for (int i = 0; i < ISSUE_W; i++) begin
                for (int f = 0; f < NUM_FU; f++) begin
                    if (sel_vec[i*NUM_FU + f]) begin
                        fu_busy[f]  <= 1'b1;
                        fu_rd[f]    <= sb.lane_rd[i*RA_W +: RA_W];
                        fu_rd_en[f] <= sb.lane_rd_en[i];
                        if (sb.lane_rd_en[i] && (sb.lane_rd[i*RA_W +: RA_W] != '0))
                            pend[sb.lane_rd[i*RA_W +: RA_W]] <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef SB_PERF_CNT_EN
    // Lane-0 causes are already zero when it issues, is flushed or invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_data   <= '0;
            cnt_struct <= '0;
            cnt_serial <= '0;
        end else begin
            if (cause_vec[SB_CAUSE_DATA])   cnt_data   <= cnt_data + 32'd1;
            if (cause_vec[SB_CAUSE_STRUCT]) cnt_struct <= cnt_struct + 32'd1;
            if (cause_vec[SB_CAUSE_SERIAL]) cnt_serial <= cnt_serial + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sb_issue_ctrl.sv
// Directed bench for sb_issue_ctrl (2 lanes, 3 FUs, 32 registers).
// Covers independent issue, RAW/WAW/WAR, x0, struct, serial, flush and reset.
module tb_sb_issue_ctrl;
    import sb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    sb_issue_ctrl_if #(.ISSUE_W(2), .NUM_FU(3), .RA_W(5)) sb_bus ();

`ifdef SB_PERF_CNT_EN
    logic [31:0] cnt_data, cnt_struct, cnt_serial;
`endif

    sb_issue_ctrl #(.ISSUE_W(2), .NUM_FU(3), .NREG(32), .RA_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_bus)
`ifdef SB_PERF_CNT_EN
        ,
        .cnt_data   (cnt_data),
        .cnt_struct (cnt_struct),
        .cnt_serial (cnt_serial)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic clear_lanes();
        sb_bus.lane_vld    = '0;
        sb_bus.lane_rs1    = '0;
        sb_bus.lane_rs2    = '0;
        sb_bus.lane_rs1_en = '0;
        sb_bus.lane_rs2_en = '0;
        sb_bus.lane_rd     = '0;
        sb_bus.lane_rd_en  = '0;
        sb_bus.lane_fu_ok  = '0;
        sb_bus.lane_serial = '0;
        sb_bus.flush       = 1'b0;
        sb_bus.fu_done     = '0;
    endtask

    task automatic set_lane(input int ln, input logic [4:0] rs1, input logic rs1_en,
                            input logic [4:0] rs2, input logic rs2_en,
                            input logic [4:0] rd, input logic rd_en,
                            input logic [2:0] ok, input logic serial);
        sb_bus.lane_vld[ln]          = 1'b1;
        sb_bus.lane_rs1[ln*5 +: 5]   = rs1;
        sb_bus.lane_rs1_en[ln]       = rs1_en;
        sb_bus.lane_rs2[ln*5 +: 5]   = rs2;
        sb_bus.lane_rs2_en[ln]       = rs2_en;
        sb_bus.lane_rd[ln*5 +: 5]    = rd;
        sb_bus.lane_rd_en[ln]        = rd_en;
        sb_bus.lane_fu_ok[ln*3 +: 3] = ok;
        sb_bus.lane_serial[ln]       = serial;
    endtask

    // Drive the cycle's control inputs, then move to the sampling edge.
    task automatic applyStimulus(input logic flush_v, input logic [2:0] done_v);
        sb_bus.flush   = flush_v;
        sb_bus.fu_done = done_v;
        @(negedge clk);
    endtask

    task automatic end_cycle();
        @(posedge clk);
        #1;
        clear_lanes();
    endtask

    task automatic check_bus(input string tag, input logic [1:0] issue,
                             input logic [5:0] sel, input logic [5:0] cause,
                             input logic idle);
        checkOutput({tag, ".issue"}, 32'(sb_bus.lane_issue), 32'(issue));
        checkOutput({tag, ".sel"},   32'(sb_bus.lane_fu_sel), 32'(sel));
        checkOutput({tag, ".cause"}, 32'(sb_bus.stall_cause), 32'(cause));
        checkOutput({tag, ".idle"},  32'(sb_bus.sb_idle), 32'(idle));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clear_lanes();

        // Outputs held quiet during reset even with a valid lane
        set_lane(0, 5'd0, 0, 5'd0, 0, 5'd3, 1, 3'b111, 0);
        applyStimulus(0, 3'b000);
        check_bus("rst_hold", 2'b00, 6'o00, 6'o00, 1);
        end_cycle();
        rst = 1'b0;

        // Independent pair, then x5 pending blocks a reader
        set_lane(0, 5'd0, 0, 5'd0, 0, 5'd5, 1, 3'b111, 0);
        set_lane(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 3'b111, 0);
        applyStimulus(0, 3'b000);
        check_bus("indep", 2'b11, 6'b010_001, 6'o00, 1);
        end_cycle();
        set_lane(0, 5'd5, 1, 5'd0, 0, 5'd0, 0, 3'b111, 0);
        set_lane(1, 5'd6, 1, 5'd0, 0, 5'd0, 0, 3'b111, 0);
        applyStimulus(0, 3'b000);
        check_bus("pend_x5", 2'b00, 6'o00, 6'b000_001, 0);
        end_cycle();
        applyStimulus(0, 3'b011);
        checkOutput("drain1_busy", 32'(sb_bus.sb_idle), 32'd0);
        end_cycle();
        applyStimulus(0, 3'b000);
        checkOutput("drain1_idle", 32'(sb_bus.sb_idle), 32'd1);
        end_cycle();

        // RAW inside the bundle, released the cycle after fu_done
        set_lane(0, 5'd0, 0, 5'd0, 0, 5'd5, 1, 3'b001, 0);
        set_lane(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 3'b010, 0);
        applyStimulus(0, 3'b000);
        check_bus("raw", 2'b01, 6'b000_001, 6'b001_000, 1);
        end_cycle();
        set_lane(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 3'b010, 0);
        applyStimulus(0, 3'b001);
        check_bus("raw_done", 2'b00, 6'o00, 6'b001_000, 0);
        end_cycle();
        set_lane(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 3'b010, 0);
        applyStimulus(0, 3'b000);
        check_bus("raw_go", 2'b10, 6'b010_000, 6'o00, 1);
        end_cycle();
        applyStimulus(0, 3'b010);
        end_cycle();

        // Structural stall on lane 0 blocks lane 1 despite free FU2
        set_lane(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 3'b001, 0);
        set_lane(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 3'b010, 0);
        applyStimulus(0, 3'b000);
        check_bus("fill01", 2'b11, 6'b010_001, 6'o00, 1);
        end_cycle();
        set_lane(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 3'b011, 0);
        set_lane(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 3'b100, 0);
        applyStimulus(0, 3'b000);
        check_bus("struct", 2'b00, 6'o00, 6'b000_010, 0);
        end_cycle();
        applyStimulus(0, 3'b011);
        end_cycle();

        // Serial op waits for an idle machine and runs alone
        set_lane(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 3'b100, 0);
        applyStimulus(0, 3'b000);
        check_bus("fill2", 2'b01, 6'b000_100, 6'o00, 1);
        end_cycle();
        for (int c = 0; c < 3; c++) begin
            set_lane(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 3'b001, 1);
            set_lane(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 3'b010, 0);
            applyStimulus(0, (c == 1) ? 3'b100 : 3'b000);
            if (c < 2) check_bus($sformatf("serial_wait%0d", c), 2'b00, 6'o00, 6'b000_100, 0);
            else       check_bus("serial_go", 2'b01, 6'b000_001, 6'o00, 1);
            end_cycle();
        end
        applyStimulus(0, 3'b001);
        end_cycle();
        set_lane(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 3'b001, 0);
        set_lane(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 3'b010, 1);
        applyStimulus(0, 3'b000);
        check_bus("serial_lane1", 2'b01, 6'b000_001, 6'b100_000, 1);
        end_cycle();
        applyStimulus(0, 3'b001);
        end_cycle();

        // WAW on x7 held until the first writer completes
        set_lane(0, 5'd0, 0, 5'd0, 0, 5'd7, 1, 3'b001, 0);
        applyStimulus(0, 3'b000);
        check_bus("waw_first", 2'b01, 6'b000_001, 6'o00, 1);
        end_cycle();
        for (int c = 0; c < 3; c++) begin
            set_lane(0, 5'd0, 0, 5'd0, 0, 5'd7, 1, 3'b010, 0);
            applyStimulus(0, (c == 1) ? 3'b001 : 3'b000);
            if (c < 2) check_bus($sformatf("waw_wait%0d", c), 2'b00, 6'o00, 6'b000_001, 0);
            else       check_bus("waw_go", 2'b01, 6'b000_010, 6'o00, 1);
            end_cycle();
        end
        applyStimulus(0, 3'b010);
        end_cycle();

        // WAR in a bundle and x0 are not hazards; combined data+struct cause
        set_lane(0, 5'd8, 1, 5'd0, 0, 5'd0, 1, 3'b001, 0);
        set_lane(1, 5'd0, 1, 5'd0, 0, 5'd8, 1, 3'b110, 0);
        applyStimulus(0, 3'b000);
        check_bus("war_x0", 2'b11, 6'b010_001, 6'o00, 1);
        end_cycle();
        set_lane(0, 5'd0, 1, 5'd0, 1, 5'd0, 0, 3'b100, 0);
        set_lane(1, 5'd8, 1, 5'd0, 0, 5'd0, 0, 3'b111, 0);
        applyStimulus(0, 3'b000);
        check_bus("x0_nohaz", 2'b01, 6'b000_100, 6'b011_000, 0);
        end_cycle();

        // Flush suppresses issue and causes but completions still retire
        set_lane(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 3'b111, 0);
        set_lane(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 3'b111, 0);
        applyStimulus(1, 3'b111);
        check_bus("flush", 2'b00, 6'o00, 6'o00, 0);
        end_cycle();
        applyStimulus(0, 3'b000);
        checkOutput("flush_drain_idle", 32'(sb_bus.sb_idle), 32'd1);
        end_cycle();

`ifdef SB_PERF_CNT_EN
        checkOutput("cnt_data",   cnt_data,   32'd3);
        checkOutput("cnt_struct", cnt_struct, 32'd1);
        checkOutput("cnt_serial", cnt_serial, 32'd2);
`endif

        // Reset mid-operation drops pending x9/x10 and busy FUs
        set_lane(0, 5'd0, 0, 5'd0, 0, 5'd9,  1, 3'b001, 0);
        set_lane(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 3'b010, 0);
        applyStimulus(0, 3'b000);
        check_bus("pre_rst", 2'b11, 6'b010_001, 6'o00, 1);
        end_cycle();
        rst = 1'b1;
        set_lane(0, 5'd9, 1, 5'd0, 0, 5'd0, 0, 3'b100, 0);
        applyStimulus(0, 3'b000);
        check_bus("rst_mid", 2'b00, 6'o00, 6'o00, 1);
        end_cycle();
`ifdef SB_PERF_CNT_EN
        checkOutput("cnt_data_rst",   cnt_data,   32'd0);
        checkOutput("cnt_struct_rst", cnt_struct, 32'd0);
        checkOutput("cnt_serial_rst", cnt_serial, 32'd0);
`endif
        rst = 1'b0;
        set_lane(0, 5'd9, 1, 5'd10, 1, 5'd0, 0, 3'b001, 0);
        applyStimulus(0, 3'b000);
        check_bus("post_rst", 2'b01, 6'b000_001, 6'o00, 1);
        end_cycle();
        applyStimulus(0, 3'b001);
        end_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sb_issue_ctrl.md
# sb_issue_ctrl

Parametrised in-order multi-issue scoreboard between the decode stage and the execute units (ALUs, MMU/LSU). It tracks pending destination registers and unit occupancy in registered tables. Each cycle it decides which decode lanes issue and binds each issuing lane to a free functional unit. It replaces pc-comparison hazard logic with lane-order (lane 0 oldest) checking and adds RAW, serialisation and drain handling.

## Interface
Parameters:
- ISSUE_W, 2, decode lanes; lane 0 is oldest in program order
- NUM_FU, 3, functional units; index f is FU f
- NREG, 32, architectural registers; x0 is never tracked
- RA_W, 5, register address width, $clog2(NREG)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- lane_vld  in  ISSUE_W  lane holds a decoded instruction
- lane_rs1/lane_rs2  in  ISSUE_W*RA_W  source addresses
- lane_rs1_en/lane_rs2_en  in  ISSUE_W  source read enables
- lane_rd  in  ISSUE_W*RA_W  destination address
- lane_rd_en  in  ISSUE_W  destination write enable
- lane_fu_ok  in  ISSUE_W*NUM_FU  mask of FUs able to execute the lane
- lane_serial  in  ISSUE_W  CSR/trap/interrupt-carrying op; must run alone on idle machine
- flush  in  1  suppress all issue this cycle; tables untouched
- fu_done  in  NUM_FU  FU f completes and writes back this cycle
- lane_issue  out  ISSUE_W  lane issues this cycle
- lane_fu_sel  out  ISSUE_W*NUM_FU  one-hot FU grant per lane, 0 if not issuing
- stall_cause  out  ISSUE_W*3  per lane {serial, struct, data} reason for non-issue
- sb_idle  out  1  no FU busy, no register pending

## Operation
- State: pend[NREG] bits; fu_busy[NUM_FU]; fu_rd[NUM_FU] (RA_W) plus fu_rd_en[NUM_FU].
- Data hazard for lane i: enabled source or destination hits pend. An enabled source or destination also hazards if it matches an older issuing lane's enabled rd (RAW/WAW). A lane rd that matches an older issuing lane's enabled source (WAR) is not a hazard, because the older lane reads at issue. Address 0 never hazards.
- Structural: grant is the lowest-index f with lane_fu_ok, !fu_busy[f] and not granted to an older lane. No such f gives a struct stall.
- Serial: lane i issues only if i==0, no FU busy, and pend all zero. Lanes younger than an issuing serial lane do not issue.
- In-order: lane i issues only if lane_vld[i], no hazard, a grant exists, !flush, and all older valid lanes issue.
- stall_cause reports every applicable cause for lanes that do not issue because of their own condition. It is 0 for issuing lanes and for lanes blocked only by an older lane.
- On issue to f: fu_busy[f]<=1; fu_rd/fu_rd_en<=lane rd; pend[rd]<=1 if rd_en and rd!=0.
- On fu_done[f]: fu_busy[f]<=0; pend[fu_rd[f]]<=0 if fu_rd_en[f].
- fu_done[f] while !fu_busy[f] is ignored. Issue to f and done of f in the same cycle cannot occur, since grants only go to FUs not busy.
- Simultaneous set and clear of the same pend bit cannot occur: WAW blocks the new writer while the bit is pending.

## Timing
- Issue decision is combinational from registered tables and same-cycle inputs: zero-cycle latency.
- Table updates become visible the next cycle. A dependent of a fu_done result issues no earlier than the cycle after fu_done.
- Reset: pend, fu_busy, fu_rd, fu_rd_en cleared. While rst=1, lane_issue=0, lane_fu_sel=0, stall_cause=0, sb_idle=1.
- Reset mid-operation drops all in-flight tracking. FUs are reset by the same rst.
- flush=1: lane_issue=0 and stall_cause=0 that cycle; fu_done is still processed.

## Configuration
- SB_PERF_CNT_EN defined: three 32-bit wrapping counters cnt_data, cnt_struct, cnt_serial, exposed as output ports. Each increments once per cycle in which lane 0 is valid, not issuing, not flushed, and has that cause set. All clear on rst.
- Undefined: counters and their ports are absent; all other behaviour is identical.

## Structure
- Shared package sb_pkg: cause bit indices (SB_CAUSE_DATA=0, SB_CAUSE_STRUCT=1, SB_CAUSE_SERIAL=2) and default parameter constants.
- One sub-module, sb_fu_pick: combinational lowest-index free-FU picker taking ok mask and claimed mask, returning a one-hot grant. It is instantiated per lane and chained with accumulated claims.

## Test plan
- Both lanes independent ALU ops (rd x5, x6), FUs idle: lane_issue=2'b11, lane0 FU0, lane1 FU1. Next cycle pend[5] and pend[6] are set.
- Lane1 reads x5 written by lane0 in the same bundle: lane_issue=2'b01, lane1 stall_cause=data. After fu_done[0] the next cycle, lane1 issues the cycle after that.
- FU0 and FU1 busy, lane0 fu_ok=3'b011: lane0 struct stall. Lane1 blocked with cause 0 and does not issue even though FU2 is free.
- lane0 serial with FU2 busy: no issue, cause=serial. Issues once fu_done[2] has cleared the table. A valid lane1 does not issue that cycle.
- WAW: issue write x7 to FU0. Next cycle lane0 writes x7: data stall until fu_done[0], then issues.
- rst asserted with pend and fu_busy set: next cycle sb_idle=1 and all outputs 0. With SB_PERF_CNT_EN, counters read 0.
